// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops and bit-serial shifts
// with a registered result, zero flag and one-cycle done pulse.

package alu_seq_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;
endpackage

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_start,
  input  logic [DATA_WIDTH-1:0] alu_operand1,
  input  logic [DATA_WIDTH-1:0] alu_operand2,
  input  alu_op_t               alu_op,
  output logic                  alu_busy,
  output logic                  alu_done,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_zero
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_t;

  state_t                state_q,  state_d;
  logic [DATA_WIDTH-1:0] work_q,   work_d;
  logic [4:0]            cnt_q,    cnt_d;
  shift_t                shk_q,    shk_d;
  logic                  fill_q,   fill_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q,   zero_d;
  logic                  done_q,   done_d;

  // Decode of the operation presented at the inputs
  logic [DATA_WIDTH-1:0] imm_val;
  logic                  is_shift;
  shift_t                shk_sel;
  logic [4:0]            shamt;
  logic                  sign_fill;

  // One bit-position step of the selected shift; the SRA fill is the saved
  // sign of the original operand rather than the current msb.
  function automatic logic [DATA_WIDTH-1:0] shift_step(
    input logic [DATA_WIDTH-1:0] v,
    input shift_t                kind,
    input logic                  fill
  );
    logic [DATA_WIDTH-1:0] r;
    case (kind)
      SH_LL:   r = {v[DATA_WIDTH-2:0], 1'b0};
      SH_RL:   r = {1'b0, v[DATA_WIDTH-1:1]};
      default: r = {fill, v[DATA_WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Combinational ALU for single-cycle ops and shift-kind decode
  always_comb begin
    imm_val   = alu_operand1 + alu_operand2;
    is_shift  = 1'b0;
    shk_sel   = SH_LL;
    shamt     = alu_operand2[4:0];
    sign_fill = alu_operand1[DATA_WIDTH-1];
    case (alu_op)
      ALU_ADD:  imm_val = alu_operand1 + alu_operand2;
      ALU_SUB:  imm_val = alu_operand1 - alu_operand2;
      ALU_AND:  imm_val = alu_operand1 & alu_operand2;
      ALU_OR:   imm_val = alu_operand1 | alu_operand2;
      ALU_XOR:  imm_val = alu_operand1 ^ alu_operand2;
      ALU_SLT:  imm_val = DATA_WIDTH'($signed(alu_operand1) < $signed(alu_operand2));
      ALU_SLTU: imm_val = DATA_WIDTH'(alu_operand1 < alu_operand2);
      ALU_SLL: begin
        is_shift = 1'b1;
        shk_sel  = SH_LL;
      end
      ALU_SRL: begin
        is_shift = 1'b1;
        shk_sel  = SH_RL;
      end
      ALU_SRA: begin
        is_shift = 1'b1;
        shk_sel  = SH_RA;
      end
      default:  imm_val = alu_operand1 + alu_operand2;
    endcase
  end

  // Next-state logic: accept in IDLE, step the shift in SHIFT
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    shk_d    = shk_q;
    fill_d   = fill_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (alu_start) begin
          if (!is_shift) begin
            result_d = imm_val;
            zero_d   = (imm_val == '0);
            done_d   = 1'b1;
          end else if (shamt == 5'd0) begin
            result_d = alu_operand1;
            zero_d   = (alu_operand1 == '0);
            done_d   = 1'b1;
          end else if (shamt == 5'd1) begin
            result_d = shift_step(alu_operand1, shk_sel, sign_fill);
            zero_d   = (shift_step(alu_operand1, shk_sel, sign_fill) == '0);
            done_d   = 1'b1;
          end else begin
            // First step happens on the accepting edge; cnt holds steps left.
            work_d  = shift_step(alu_operand1, shk_sel, sign_fill);
            cnt_d   = shamt - 5'd1;
            shk_d   = shk_sel;
            fill_d  = sign_fill;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q <= 5'd1) begin
          result_d = shift_step(work_q, shk_q, fill_q);
          zero_d   = (shift_step(work_q, shk_q, fill_q) == '0);
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          work_d = shift_step(work_q, shk_q, fill_q);
          cnt_d  = cnt_q - 5'd1;
        end
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      shk_q    <= SH_LL;
      fill_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      shk_q    <= shk_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign alu_busy   = (state_q == ST_SHIFT);
  assign alu_done   = done_q;
  assign alu_result = result_q;
  assign alu_zero   = zero_q;

endmodule
